// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, talks req/gnt/rvalid to imem,
// and holds one fetched instruction in a valid/ready buffer toward ID.
module if_fetch_unit #(
  parameter logic [63:0] PC_ENTRY = 64'h0000_0000_8000_0000,
  parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [63:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] pc_if_o,
  output logic [31:0] inst_if_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] pc_if_q, pc_if_d;
  logic [31:0] inst_q, inst_d;
  logic        valid_q, valid_d;
  logic        buf_free;
  logic        req;

  always_comb begin
    buf_free = !valid_q || out_ready_i;
    req      = rst_n && (state_q == S_REQ)
            && buf_free && !redirect_valid_i;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pc_if_d = pc_if_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
      inst_d  = INST_NOP;
    end
    if (redirect_valid_i) begin
      pc_d    = {redirect_pc_i[63:2], 2'b00};
      valid_d = 1'b0;
      inst_d  = INST_NOP;
      unique case (state_q)
        S_REQ:   state_d = S_REQ;
        S_WAIT,
        S_DRAIN: state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req && imem_gnt_i) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            pc_if_d = pc_q;
            inst_d  = imem_rdata_i;
            valid_d = 1'b1;
            pc_d    = pc_q + 64'd4;
            state_d = S_REQ;
          end
        end
        S_DRAIN: begin
          // the cancelled fetch's response is swallowed here
          if (imem_rvalid_i) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
      pc_q    <= PC_ENTRY;
      pc_if_q <= PC_ENTRY;
      inst_q  <= INST_NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pc_if_q <= pc_if_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign imem_req_o  = req;
  assign imem_addr_o = pc_q;
  assign out_valid_o = valid_q;
  assign pc_if_o     = pc_if_q;
  assign inst_if_o   = valid_q ? inst_q : INST_NOP;

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
Instruction-fetch stage that produces the PC/instruction pair consumed by the IF/ID pipeline register. It owns the architectural fetch PC and issues requests to the instruction memory over a request/grant + response-valid interface. Each returned instruction is held in a one-entry output buffer with a valid/ready handshake toward ID. Redirects from EX (branch/jump) or trap logic cancel stale fetches.

Parameters:
PC_ENTRY, 64'h0000_0000_8000_0000, fetch PC after reset.
INST_NOP, 32'h0000_0013, value driven on inst_if_o while invalid or after reset (addi x0,x0,0).

Ports:
clk  input  1  clock, all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
redirect_valid_i  input  1  redirect fetch this cycle.
redirect_pc_i  input  64  redirect target.
imem_req_o  output  1  instruction fetch request.
imem_addr_o  output  64  fetch address (always = fetch PC).
imem_gnt_i  input  1  request accepted this cycle.
imem_rvalid_i  input  1  response data valid.
imem_rdata_i  input  32  response instruction.
out_valid_o  output  1  output buffer holds a valid instruction.
out_ready_i  input  1  IF/ID accepts the buffer this cycle.
pc_if_o  output  64  PC of buffered instruction.
inst_if_o  output  32  buffered instruction.

Behaviour:
- Reset (async, rst_n=0): fetch PC=PC_ENTRY, state=REQ, out_valid_o=0, pc_if_o=PC_ENTRY, inst_if_o=INST_NOP. imem_req_o is held low while rst_n=0.
- States: REQ, WAIT, DRAIN. The PC is held in a separate register; imem_addr_o = PC in every state.
- Buffer free condition: buf_free = !out_valid_o || out_ready_i.
- REQ state:
  - imem_req_o = buf_free && !redirect_valid_i.
  - req && gnt -> WAIT.
  - Otherwise stay in REQ. The PC is unchanged while waiting for a grant.
- WAIT state:
  - imem_req_o = 0; wait for imem_rvalid_i, for any number of cycles.
  - On rvalid: pc_if_o <= PC, inst_if_o <= imem_rdata_i, out_valid_o <= 1, PC <= PC + 4 (64-bit wrap), state -> REQ.
  - Only one request is ever outstanding.
- DRAIN state: imem_req_o = 0. The next rvalid is discarded, with no change to the buffer or PC; state -> REQ.
- Output handshake:
  - out_valid_o && out_ready_i consumes the buffer.
  - out_valid_o falls next cycle unless a new response loads the buffer in the same cycle; the load wins and out_valid_o stays 1.
  - pc_if_o and inst_if_o are stable while out_valid_o=1 && !out_ready_i.
  - When out_valid_o=0, inst_if_o = INST_NOP.
- Redirect (highest priority, any state):
  - Next cycle: PC <= {redirect_pc_i[63:2],2'b00}, out_valid_o <= 0, inst_if_o <= INST_NOP.
  - Any rvalid in the redirect cycle is dropped.
  - State on redirect:
    - In REQ: -> REQ.
    - In WAIT without rvalid this cycle: -> DRAIN.
    - In WAIT with rvalid this cycle: -> REQ, response dropped.
    - In DRAIN without rvalid: stay in DRAIN.
    - In DRAIN with rvalid: -> REQ.
- rvalid while in REQ is a protocol error and is ignored.
- Throughput: one instruction per 2 cycles with 1-cycle memory latency and gnt=1. Latency from grant to out_valid_o is (memory latency + 1) cycles.

Test Plan:
- Reset release, gnt=1, rdata=32'h00000093 one cycle after grant, ready=1 -> first req addr 0x80000000; out_valid_o=1 with pc_if_o=0x80000000 and inst=0x00000093; next req addr 0x80000004.
- Back-pressure: out_ready_i=0 for 5 cycles with buffer full -> imem_req_o=0, pc_if_o/inst_if_o unchanged; ready=1 -> req reasserted the same cycle.
- Redirect in WAIT to 0x80001002, stale rvalid 3 cycles later with 0xDEADBEEF -> stale data never appears on out_valid_o; next req addr 0x80001000.
- Redirect coincident with rvalid in WAIT -> response dropped, out_valid_o=0 next cycle, state REQ, addr = redirect target.
- gnt held low 4 cycles -> req stays high, addr constant, no PC advance.
- Assert rst_n=0 mid-WAIT -> outputs return to reset values immediately (async); a later rvalid after release is ignored as a REQ-state protocol error, and the first req is at PC_ENTRY.
